hdlc_rx_protocol_checker: RTL and testbench
===========================================

Name: hdlc_rx_protocol_checker

Overview:
Synthesizable, parametrised protocol checker for the HDLC Rx path. It monitors the serial Rx line and Rx status outputs on the same clock and recomputes the expected FlagDetect, AbortSignal and EoF events with configurable latency. It flags missing events and, in strict mode, spurious ones, keeping saturating per-check error counters. It runs beside the Rx module in simulation and on FPGA debug builds, where concurrent assertions are unavailable.

Parameters:
FLAG_LAT, 2, cycles from the last bit of a received flag to the expected Rx_FlagDetect (1..8)
ABORT_LAT, 1, cycles from (Rx_AbortDetect && Rx_ValidFrame) to the expected Rx_AbortSignal (1..8)
EOF_LAT, 1, cycles from the falling edge of Rx_ValidFrame to the expected Rx_EoF (1..8)
CNT_W, 8, width of each per-check error counter

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous reset, active-low
Rx  input  1  serial receive line
Rx_FlagDetect  input  1  DUT flag detect
Rx_AbortDetect  input  1  DUT abort detect
Rx_ValidFrame  input  1  DUT valid frame
Rx_AbortSignal  input  1  DUT abort signal
Rx_EoF  input  1  DUT end of frame
Chk_En  input  3  per-check enable: [0] flag, [1] abort, [2] eof
Strict  input  1  1 = also report spurious events
Clr  input  1  synchronous clear of counters and sticky flags
ErrPulse  output  3  one-cycle error strobe per check, same bit order as Chk_En
ErrSticky  output  3  sticky error flags
ErrCntFlag  output  CNT_W  flag-check error count
ErrCntAbort  output  CNT_W  abort-check error count
ErrCntEof  output  CNT_W  eof-check error count
ErrCntTotal  output  CNT_W+2  total error count

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0; shift window, expectation pipes, warm-up counter and previous-ValidFrame register cleared.
- Rx window: 8-bit shift register W samples Rx every cycle. A 4-bit warm-up counter saturates at 8. Pattern matching is enabled only once 8 samples are collected after reset.
- Flag match at cycle t: W, oldest to newest, = 0,1,1,1,1,1,1,0. Overlapping matches are allowed (e.g. back-to-back flags sharing a 0).
- Abort trigger at t: Rx_AbortDetect && Rx_ValidFrame, both sampled at t.
- EoF trigger at t: Rx_ValidFrame=0 at t and 1 at t-1. The previous value resets to 0, so no trigger occurs on the first cycle after reset.
- Each trigger enters a per-check expectation shift pipe of length LAT. The expectation for a trigger at t matures at cycle t+LAT.
- Check at each cycle, per check k:
  - Missing: expectation matured and the DUT signal is 0.
  - Spurious: Strict=1, no expectation matured, and the DUT signal is 1.
  - Either condition with Chk_En[k]=1 is an error; ErrPulse[k] is registered high on the next cycle.
- Chk_En is sampled at the comparison cycle. Pipes always shift, and disabling a check discards its matured expectations without error.
- Counters: each per-check counter increments by 1 per error and saturates at 2^CNT_W-1.
  - ErrCntTotal adds the number of simultaneous errors (0..3) and saturates at 2^(CNT_W+2)-1.
  - ErrCntTotal is independent of per-check saturation.
- ErrSticky[k] sets with ErrPulse[k] and holds until Clr or reset.
- Clr=1: counters and ErrSticky go to 0 on the next edge; Clr wins over a simultaneous increment. ErrPulse is not suppressed by Clr. Pipes and window are not affected by Clr.
- Reset mid-frame: pending expectations are dropped, warm-up restarts, and no error is reported for them.
- A DUT event that matches an expectation early or late by one cycle counts as one missing error. It also counts as one spurious error if Strict=1.

Test Plan:
- Rx = 1,1,0,1,1,1,1,1,1,0 then 1s; DUT asserts FlagDetect 2 cycles after the final 0 -> ErrCntFlag=0, ErrPulse never high.
- Same flag stimulus, FlagDetect held 0 -> ErrPulse[0] high for 1 cycle at last-0+3, ErrCntFlag=1, ErrSticky=3'b001, ErrCntTotal=1.
- ValidFrame=1 and AbortDetect pulse at t, AbortSignal at t+2 (ABORT_LAT=1), Strict=1 -> ErrCntAbort=2 (one missing, one spurious); Strict=0 -> ErrCntAbort=1.
- ValidFrame falls at t with no EoF while a missing flag matures in the same cycle -> ErrCntTotal increments by 2. Then pulse Clr -> all counters 0, ErrSticky=0.
- CNT_W=2: force 5 flag misses -> ErrCntFlag saturates at 3, ErrCntTotal=5.
- Assert Rst low 1 cycle after a flag (FLAG_LAT=2) -> no error reported. Feed the flag pattern in the first 7 cycles after reset -> no match and no error.

Source files
------------

// File: rtl/hdlc_rx_protocol_checker.sv
// hdlc_rx_protocol_checker: recomputes HDLC Rx flag/abort/EoF events from the line and Rx status
// and flags missing (and, in strict mode, spurious) DUT events with saturating error counters.
module hdlc_rx_protocol_checker #(
    parameter int FLAG_LAT  = 2,
    parameter int ABORT_LAT = 1,
    parameter int EOF_LAT   = 1,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Rx,
    input  logic             Rx_FlagDetect,
    input  logic             Rx_AbortDetect,
    input  logic             Rx_ValidFrame,
    input  logic             Rx_AbortSignal,
    input  logic             Rx_EoF,
    input  logic [2:0]       Chk_En,
    input  logic             Strict,
    input  logic             Clr,
    output logic [2:0]       ErrPulse,
    output logic [2:0]       ErrSticky,
    output logic [CNT_W-1:0] ErrCntFlag,
    output logic [CNT_W-1:0] ErrCntAbort,
    output logic [CNT_W-1:0] ErrCntEof,
    output logic [CNT_W+1:0] ErrCntTotal
);
    localparam logic [CNT_W+2:0] TOTAL_MAX = {1'b0, {(CNT_W + 2){1'b1}}};

    logic [7:0]           w;
    logic [7:0]           win;
    logic [3:0]           warm;
    logic                 prev_vf;
    logic [FLAG_LAT-1:0]  flag_pipe;
    logic [ABORT_LAT-1:0] abort_pipe;
    logic [EOF_LAT-1:0]   eof_pipe;
    logic [FLAG_LAT:0]    flag_ext;
    logic [ABORT_LAT:0]   abort_ext;
    logic [EOF_LAT:0]     eof_ext;
    logic                 flag_trig;
    logic                 abort_trig;
    logic                 eof_trig;
    logic [2:0]           mat;
    logic [2:0]           sig;
    logic [2:0]           err;
    logic [1:0]           nerr;
    logic [CNT_W+2:0]     total_sum;
    logic [CNT_W-1:0]     cnt [3];
    logic [CNT_W+1:0]     total;

    // Window includes the current Rx sample so a match lands on the flag's last bit
    assign win        = {w[6:0], Rx};
    assign flag_trig  = (warm >= 4'd7) && (win == 8'b0111_1110);
    assign abort_trig = Rx_AbortDetect && Rx_ValidFrame;
    assign eof_trig   = prev_vf && !Rx_ValidFrame;
    assign flag_ext   = {flag_pipe, flag_trig};
    assign abort_ext  = {abort_pipe, abort_trig};
    assign eof_ext    = {eof_pipe, eof_trig};

    always_comb begin
        mat       = {eof_pipe[EOF_LAT-1], abort_pipe[ABORT_LAT-1], flag_pipe[FLAG_LAT-1]};
        sig       = {Rx_EoF, Rx_AbortSignal, Rx_FlagDetect};
        err       = Chk_En & ((mat & ~sig) | ({3{Strict}} & ~mat & sig));
        nerr      = {1'b0, err[0]} + {1'b0, err[1]} + {1'b0, err[2]};
        total_sum = {1'b0, total} + {{(CNT_W + 1){1'b0}}, nerr};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            w          <= '0;
            warm       <= '0;
            prev_vf    <= 1'b0;
            flag_pipe  <= '0;
            abort_pipe <= '0;
            eof_pipe   <= '0;
        end else begin
            w          <= win;
            warm       <= (warm == 4'd8) ? warm : warm + 4'd1;
            prev_vf    <= Rx_ValidFrame;
            flag_pipe  <= flag_ext[FLAG_LAT-1:0];
            abort_pipe <= abort_ext[ABORT_LAT-1:0];
            eof_pipe   <= eof_ext[EOF_LAT-1:0];
        end
    end

    // Clear beats a simultaneous increment; the error strobe itself is never masked
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ErrPulse  <= '0;
            ErrSticky <= '0;
            total     <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            ErrPulse  <= err;
            ErrSticky <= Clr ? 3'b000 : (ErrSticky | err);
            total     <= Clr ? '0 : (total_sum > TOTAL_MAX) ? TOTAL_MAX[CNT_W+1:0] : total_sum[CNT_W+1:0];
            for (int k = 0; k < 3; k++)
                cnt[k] <= Clr ? '0 : (err[k] && !(&cnt[k])) ? cnt[k] + CNT_W'(1) : cnt[k];
        end
    end

    assign ErrCntFlag  = cnt[0];
    assign ErrCntAbort = cnt[1];
    assign ErrCntEof   = cnt[2];
    assign ErrCntTotal = total;
endmodule

// File: tb/tb_hdlc_rx_protocol_checker.sv
// tb_hdlc_rx_protocol_checker: directed checks of the HDLC Rx protocol checker; a second
// instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_hdlc_rx_protocol_checker;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b1;
    logic       fd = 1'b0, ad = 1'b0, vf = 1'b0, as = 1'b0, eo = 1'b0;
    logic [2:0] Chk_En = 3'b111;
    logic       Strict = 1'b0;
    logic       Clr = 1'b0;
    logic [2:0] pulse, sticky, pulse2, sticky2;
    logic [7:0] cnt_flag, cnt_abort, cnt_eof;
    logic [9:0] cnt_total;
    logic [1:0] c2_flag, c2_abort, c2_eof;
    logic [3:0] c2_total;
    logic [2:0] pulse_or = 3'b000;
    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    hdlc_rx_protocol_checker dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(fd), .Rx_AbortDetect(ad),
        .Rx_ValidFrame(vf), .Rx_AbortSignal(as), .Rx_EoF(eo), .Chk_En(Chk_En),
        .Strict(Strict), .Clr(Clr), .ErrPulse(pulse), .ErrSticky(sticky),
        .ErrCntFlag(cnt_flag), .ErrCntAbort(cnt_abort), .ErrCntEof(cnt_eof),
        .ErrCntTotal(cnt_total)
    );

    hdlc_rx_protocol_checker #(.CNT_W(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(fd), .Rx_AbortDetect(ad),
        .Rx_ValidFrame(vf), .Rx_AbortSignal(as), .Rx_EoF(eo), .Chk_En(Chk_En),
        .Strict(Strict), .Clr(Clr), .ErrPulse(pulse2), .ErrSticky(sticky2),
        .ErrCntFlag(c2_flag), .ErrCntAbort(c2_abort), .ErrCntEof(c2_eof),
        .ErrCntTotal(c2_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given Rx bit; outputs are sampled 1ns after the edge
    task automatic cyc(input logic b);
        Rx = b;
        @(posedge Clk);
        #1;
        pulse_or = pulse_or | pulse;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(bits[i]);
    endtask

    initial begin
        #12;
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_sticky", 32'(sticky), 0);
        chk("rst_cnt_flag", 32'(cnt_flag), 0);
        chk("rst_cnt_abort", 32'(cnt_abort), 0);
        chk("rst_cnt_eof", 32'(cnt_eof), 0);
        chk("rst_cnt_total", 32'(cnt_total), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1);

        // Flag answered on time: no error
        send(16'b11_0111_1110, 10);
        cyc(1'b1);
        fd = 1'b1;
        cyc(1'b1);
        fd = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1);
        chk("flag_ok_cnt", 32'(cnt_flag), 0);
        chk("flag_ok_pulse", 32'(pulse_or), 0);
        chk("flag_ok_total", 32'(cnt_total), 0);

        // Flag not answered: pulse at last-0 + 3
        send(16'b11_0111_1110, 10);
        cyc(1'b1);
        chk("flag_miss_pulse_early", 32'(pulse), 0);
        cyc(1'b1);
        chk("flag_miss_pulse", 32'(pulse), 32'b001);
        cyc(1'b1);
        chk("flag_miss_pulse_end", 32'(pulse), 0);
        chk("flag_miss_cnt", 32'(cnt_flag), 1);
        chk("flag_miss_sticky", 32'(sticky), 32'b001);
        chk("flag_miss_total", 32'(cnt_total), 1);

        // Abort signal one cycle late, strict: one missing plus one spurious
        Strict = 1'b1;
        vf = 1'b1;
        cyc(1'b1);
        ad = 1'b1;
        cyc(1'b1);
        ad = 1'b0;
        cyc(1'b1);
        chk("abort_miss_pulse", 32'(pulse), 32'b010);
        as = 1'b1;
        cyc(1'b1);
        as = 1'b0;
        chk("abort_spur_pulse", 32'(pulse), 32'b010);
        cyc(1'b1);
        chk("abort_strict_cnt", 32'(cnt_abort), 2);
        chk("abort_strict_sticky", 32'(sticky), 32'b011);
        chk("abort_strict_total", 32'(cnt_total), 3);

        // Same late abort, non-strict: only the missing one counts
        Strict = 1'b0;
        ad = 1'b1;
        cyc(1'b1);
        ad = 1'b0;
        cyc(1'b1);
        as = 1'b1;
        cyc(1'b1);
        as = 1'b0;
        cyc(1'b1);
        chk("abort_lax_cnt", 32'(cnt_abort), 3);
        chk("abort_lax_total", 32'(cnt_total), 4);

        // Proper frame end: EoF one cycle after ValidFrame falls
        vf = 1'b0;
        cyc(1'b1);
        eo = 1'b1;
        cyc(1'b1);
        eo = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        chk("eof_ok_cnt", 32'(cnt_eof), 0);
        chk("eof_ok_total", 32'(cnt_total), 4);

        // Missing flag and missing EoF maturing together: total +2
        vf = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        send(16'b11_0111_1110, 10);
        vf = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        chk("dual_pulse", 32'(pulse), 32'b101);
        chk("dual_total", 32'(cnt_total), 6);
        chk("dual_cnt_flag", 32'(cnt_flag), 2);
        chk("dual_cnt_eof", 32'(cnt_eof), 1);
        chk("dual_sticky", 32'(sticky), 32'b111);
        Clr = 1'b1;
        cyc(1'b1);
        Clr = 1'b0;
        chk("clr_cnt_flag", 32'(cnt_flag), 0);
        chk("clr_cnt_abort", 32'(cnt_abort), 0);
        chk("clr_cnt_eof", 32'(cnt_eof), 0);
        chk("clr_total", 32'(cnt_total), 0);
        chk("clr_sticky", 32'(sticky), 0);
        chk("clr_total_w2", 32'(c2_total), 0);

        // Five back-to-back flags sharing their 0, none answered
        cyc(1'b0);
        for (int i = 0; i < 5; i++) send(16'b111_1110, 7);
        for (int i = 0; i < 4; i++) cyc(1'b1);
        chk("sat_cnt_flag_w2", 32'(c2_flag), 3);
        chk("sat_total_w2", 32'(c2_total), 5);
        chk("sat_cnt_flag_w8", 32'(cnt_flag), 5);
        chk("sat_total_w8", 32'(cnt_total), 5);

        // Reset one cycle after a flag drops its expectation; warm-up blocks an early match
        send(16'b11_0111_1110, 10);
        pulse_or = 3'b000;
        Rst = 1'b0;
        #2;
        chk("async_rst_cnt", 32'(cnt_flag), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        send(16'b111_1110, 7);
        for (int i = 0; i < 5; i++) cyc(1'b1);
        chk("rst_drop_pulse", 32'(pulse_or), 0);
        chk("rst_drop_cnt", 32'(cnt_flag), 0);
        chk("rst_drop_total", 32'(cnt_total), 0);
        chk("rst_drop_sticky", 32'(sticky), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
